// File: rtl/fp_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp_accum_ctrl
// Brief    : Sequencing controller around a combinational FP32 adder.
//            Reduces a programmed number of valid/ready operands into a
//            running sum and reports the result with sticky exceptions.
// Revision : 1.0 - initial release
// ============================================================================
module fp_accum_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_sub_mode,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_data,
  output logic [31:0]      o_add_a,
  output logic [31:0]      o_add_b,
  output logic             o_add_sub,
  input  logic [31:0]      i_add_op,
  input  logic             i_add_zero,
  input  logic             i_add_over,
  input  logic             i_add_under,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_result,
  output logic             o_res_zero,
  output logic             o_ovf_sticky,
  output logic             o_unf_sticky,
  output logic [LEN_W-1:0] o_elem_cnt
);

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_acc;
  logic [31:0]      r_result;
  logic             r_res_zero;
  logic             r_ovf;
  logic             r_unf;
  logic             r_sub;
  logic [LEN_W-1:0] r_len_q;
  logic [LEN_W-1:0] r_elem_cnt;

  logic             w_start_ok;
  logic             w_hs;
  logic             w_last;
  logic [LEN_W-1:0] w_len_clamp;
  logic             w_unused;

  // Zero status is derived from the captured sum bits, so the adder's own
  // zero flag is not needed.
  assign w_unused    = i_add_zero;

  assign w_start_ok  = (r_state == S_IDLE) && i_start;
  assign w_hs        = (r_state == S_ACC) && i_in_valid;
  assign w_last      = w_hs && ((r_elem_cnt + LEN_W'(1)) == r_len_q);
  assign w_len_clamp = (i_len > c_max_len) ? c_max_len : i_len;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (w_len_clamp == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accumulator, counters and sticky status. The result is captured on the
  // edge that enters DONE so it is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_result   <= '0;
      r_res_zero <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_sub      <= 1'b0;
      r_len_q    <= '0;
      r_elem_cnt <= '0;
    end else if (w_start_ok) begin
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_sub      <= i_sub_mode;
      r_len_q    <= w_len_clamp;
      r_elem_cnt <= '0;
      if (w_len_clamp == '0) begin
        r_result   <= '0;
        r_res_zero <= 1'b1;
      end
    end else if (w_hs) begin
      r_acc      <= i_add_op;
      r_elem_cnt <= r_elem_cnt + LEN_W'(1);
      r_ovf      <= r_ovf | i_add_over;
      r_unf      <= r_unf | i_add_under;
      if (w_last) begin
        r_result   <= i_add_op;
        r_res_zero <= (i_add_op[30:0] == '0);
      end
    end
  end

  assign o_in_ready   = (r_state == S_ACC);
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_add_a      = r_acc;
  assign o_add_b      = i_in_data;
  assign o_add_sub    = r_sub;
  assign o_result     = r_result;
  assign o_res_zero   = r_res_zero;
  assign o_ovf_sticky = r_ovf;
  assign o_unf_sticky = r_unf;
  assign o_elem_cnt   = r_elem_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fp_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_accum_ctrl
// Brief    : Scoreboard bench for fp_accum_ctrl. A behavioural FP32 adder
//            stands in for the external adder; expected run results come
//            from plain integer sums of the streamed operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_accum_ctrl;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             i_sub_mode;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [31:0]      i_in_data;
  logic [31:0]      o_add_a;
  logic [31:0]      o_add_b;
  logic             o_add_sub;
  logic [31:0]      i_add_op;
  logic             i_add_zero;
  logic             i_add_over;
  logic             i_add_under;
  logic             o_busy;
  logic             o_done;
  logic [31:0]      o_result;
  logic             o_res_zero;
  logic             o_ovf_sticky;
  logic             o_unf_sticky;
  logic [LEN_W-1:0] o_elem_cnt;

  fp_accum_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_len        (i_len),
    .i_sub_mode   (i_sub_mode),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_data    (i_in_data),
    .o_add_a      (o_add_a),
    .o_add_b      (o_add_b),
    .o_add_sub    (o_add_sub),
    .i_add_op     (i_add_op),
    .i_add_zero   (i_add_zero),
    .i_add_over   (i_add_over),
    .i_add_under  (i_add_under),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_result     (o_result),
    .o_res_zero   (o_res_zero),
    .o_ovf_sticky (o_ovf_sticky),
    .o_unf_sticky (o_unf_sticky),
    .o_elem_cnt   (o_elem_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      res;
    logic             z;
    logic             o;
    logic             u;
    logic [LEN_W-1:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] g_ops [32];
  logic [31:0] g_part[33];
  bit          g_vpat[16];
  int          g_vpat_len = 0;
  logic [31:0] g_exp_res;
  bit          g_exp_z;
  logic [31:0] g_last_res = 32'h0;

  // ---------------- behavioural FP helpers ----------------
  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:23] == 8'h00) return 0.0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  function automatic void r2f(input real r, output logic [31:0] op,
                              output logic z, output logic o, output logic u);
    logic [63:0] b;
    int          e;
    o = 1'b0; u = 1'b0; z = 1'b0;
    if (r == 0.0) begin
      op = 32'h0; z = 1'b1;
      return;
    end
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023;
    if (e > 127) begin
      op = {b[63], 8'hFF, 23'h0}; o = 1'b1;
    end else if (e < -126) begin
      op = {b[63], 31'h0}; u = 1'b1; z = 1'b1;
    end else begin
      op = {b[63], 8'(e + 127), b[51:29]};
    end
  endfunction

  function automatic logic [31:0] int2f(input int v);
    logic [31:0] f;
    logic        z, o, u;
    r2f(real'(v), f, z, o, u);
    return f;
  endfunction

  // Stand-in adder. Off-handshake cycles return junk and raise both flags so
  // that any capture outside a handshake is visible.
  logic [31:0] m_op;
  logic        m_z, m_o, m_u;
  always_comb begin
    m_op = 32'h0; m_z = 1'b0; m_o = 1'b0; m_u = 1'b0;
    r2f(f2r(o_add_a) + (o_add_sub ? -f2r(o_add_b) : f2r(o_add_b)), m_op, m_z, m_o, m_u);
    if (i_in_valid && o_in_ready) begin
      i_add_op = m_op; i_add_zero = m_z; i_add_over = m_o; i_add_under = m_u;
    end else begin
      i_add_op = 32'hDEAD_BEEF; i_add_zero = 1'b0; i_add_over = 1'b1; i_add_under = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor: pops on every done pulse ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_done) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 expected no run pending");
      end else begin
        e = sb.pop_front();
        chk("result",   o_result,     e.res);
        chk("res_zero", o_res_zero,   32'(e.z));
        chk("ovf",      o_ovf_sticky, 32'(e.o));
        chk("unf",      o_unf_sticky, 32'(e.u));
        chk("cnt_done", o_elem_cnt,   32'(e.cnt));
      end
    end
  end

  // Random integer operands; reference = signed running integer sum.
  task automatic prep_int(input int len, input bit sub);
    int s, lq, v;
    s  = 0;
    lq = (len > MAX_LEN) ? MAX_LEN : len;
    g_part[0] = 32'h0;
    for (int k = 0; k < 32; k++) begin
      v = int'($urandom_range(0, 2000)) - 1000;
      g_ops[k] = int2f(v);
      s = s + v;
      g_part[k+1] = int2f(sub ? -s : s);
      if (k + 1 == lq) begin
        g_exp_res = g_part[k+1];
        g_exp_z   = (s == 0);
      end
    end
    if (lq == 0) begin g_exp_res = 32'h0; g_exp_z = 1'b1; end
  endtask

  task automatic prep_list(input int n, input int vals[4], input bit sub);
    int s;
    s = 0;
    g_part[0] = 32'h0;
    for (int k = 0; k < n; k++) begin
      g_ops[k] = int2f(vals[k]);
      s = s + vals[k];
      g_part[k+1] = int2f(sub ? -s : s);
    end
    g_exp_res = g_part[n];
    g_exp_z   = (s == 0);
  endtask

  task automatic run_case(input int len, input bit sub, input logic [31:0] exp_res,
                          input bit exp_z, input bit exp_o, input bit exp_u);
    int   lq, n, cyc;
    bit   v;
    exp_t e;
    lq = (len > MAX_LEN) ? MAX_LEN : len;
    e.res = exp_res; e.z = exp_z; e.o = exp_o; e.u = exp_u; e.cnt = LEN_W'(lq);
    sb.push_back(e);
    @(negedge clk);
    i_start = 1'b1; i_len = LEN_W'(len); i_sub_mode = sub;
    @(negedge clk);
    i_start = 1'b0; i_len = LEN_W'($urandom); i_sub_mode = 1'($urandom);
    chk("start_ovf_clr", o_ovf_sticky, 32'h0);
    chk("start_unf_clr", o_unf_sticky, 32'h0);
    if (lq == 0) chk("len0_ready", o_in_ready, 32'h0);
    else begin
      chk("held_result", o_result, g_last_res);
      chk("busy_run", o_busy, 32'h1);
    end
    n = 0; cyc = 0;
    while (n < lq && cyc < 400) begin
      chk("elem_cnt", o_elem_cnt, 32'(n));
      chk("acc",      o_add_a,    g_part[n]);
      chk("in_ready", o_in_ready, 32'h1);
      chk("add_sub",  o_add_sub,  32'(sub));
      v = (g_vpat_len > 0) ? g_vpat[cyc % g_vpat_len] : ($urandom_range(0, 99) < 65);
      i_in_valid = v;
      i_in_data  = v ? g_ops[n] : $urandom;
      i_start    = ($urandom_range(0, 7) == 0);
      i_len      = LEN_W'($urandom);
      @(negedge clk);
      if (v) n++;
      cyc++;
    end
    if (n < lq) begin
      total++; bad++;
      $display("FAIL stream_timeout: got %0d handshakes expected %0d", n, lq);
    end
    i_in_valid = 1'($urandom); i_in_data = $urandom; i_start = 1'($urandom);
    chk("done_latency", o_done, 32'h1);
    @(negedge clk);
    i_start = 1'b0; i_in_valid = 1'b0;
    chk("done_pulse", o_done, 32'h0);
    chk("idle_after", o_busy, 32'h0);
    g_last_res = exp_res;
  endtask

  initial begin
    int vals[4];
    rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_sub_mode = 1'b0;
    i_in_valid = 1'b0; i_in_data = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  o_busy,       32'h0);
    chk("rst_done",  o_done,       32'h0);
    chk("rst_ready", o_in_ready,   32'h0);
    chk("rst_res",   o_result,     32'h0);
    chk("rst_rz",    o_res_zero,   32'h0);
    chk("rst_ovf",   o_ovf_sticky, 32'h0);
    chk("rst_unf",   o_unf_sticky, 32'h0);
    chk("rst_cnt",   o_elem_cnt,   32'h0);
    chk("rst_acc",   o_add_a,      32'h0);
    chk("rst_sub",   o_add_sub,    32'h0);
    rst_n = 1'b1;

    // 1 and 2: 1+2+3 add then subtract, valid held.
    g_vpat[0] = 1'b1; g_vpat_len = 1;
    vals = '{1, 2, 3, 0};
    prep_list(3, vals, 1'b0);
    chk("ref_6", g_exp_res, 32'h40C0_0000);
    run_case(3, 1'b0, 32'h40C0_0000, 1'b0, 1'b0, 1'b0);
    prep_list(3, vals, 1'b1);
    run_case(3, 1'b1, 32'hC0C0_0000, 1'b0, 1'b0, 1'b0);

    // 3: overflow on second element, then a clean run clears the flag.
    g_ops[0] = 32'h7F7F_FFFF; g_ops[1] = 32'h7F7F_FFFF;
    g_part[0] = 32'h0; g_part[1] = 32'h7F7F_FFFF;
    run_case(2, 1'b0, 32'h7F80_0000, 1'b0, 1'b1, 1'b0);
    prep_list(3, vals, 1'b0);
    run_case(3, 1'b0, 32'h40C0_0000, 1'b0, 1'b0, 1'b0);

    // 4: backpressure pattern 1,0,0,1,1,0,1 with 1.0 operands.
    g_vpat = '{default: 1'b0};
    g_vpat[0] = 1; g_vpat[3] = 1; g_vpat[4] = 1; g_vpat[6] = 1; g_vpat_len = 7;
    vals = '{1, 1, 1, 1};
    prep_list(4, vals, 1'b0);
    run_case(4, 1'b0, 32'h4080_0000, 1'b0, 1'b0, 1'b0);
    g_vpat_len = 0;

    // 5: len 0 and clamped len 31.
    run_case(0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    prep_int(31, 1'b0);
    run_case(31, 1'b0, g_exp_res, g_exp_z, 1'b0, 1'b0);

    // Randomised runs with random gaps and ignored start pulses.
    for (int r = 0; r < 24; r++) begin
      int  len;
      bit  sub;
      len = $urandom_range(0, 31);
      sub = 1'($urandom);
      prep_int(len, sub);
      run_case(len, sub, g_exp_res, g_exp_z, 1'b0, 1'b0);
    end

    // 6: reset after two of three handshakes aborts with no done.
    vals = '{1, 2, 3, 0};
    prep_list(3, vals, 1'b0);
    @(negedge clk);
    i_start = 1'b1; i_len = 5'd3; i_sub_mode = 1'b0;
    @(negedge clk);
    i_start = 1'b0; i_in_valid = 1'b1; i_in_data = g_ops[0];
    @(negedge clk);
    i_in_data = g_ops[1];
    @(negedge clk);
    chk("pre_rst_cnt", o_elem_cnt, 32'h2);
    i_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy",  o_busy,     32'h0);
    chk("abort_ready", o_in_ready, 32'h0);
    chk("abort_acc",   o_add_a,    32'h0);
    chk("abort_cnt",   o_elem_cnt, 32'h0);
    chk("abort_done",  o_done,     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    g_last_res = 32'h0;
    g_vpat[0] = 1'b1; g_vpat_len = 1;
    run_case(3, 1'b0, 32'h40C0_0000, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
